sv_remapper_multitap: RTL
=========================

// Module: sv_remapper_multitap
// PURPOSE
// - Parametrised successor of the fixed 12k remapper: one pixel/beat AXI-Stream in, one pixel/beat out.
// - Input is a sensor stream in which each KERNEL-pixel kernel arrives tap-interleaved across TAPS taps.
// - Reorders each kernel into linear pixel order and regenerates tuser/tlast from i_width/i_height.
// - Adds full AXI-Stream backpressure (m_axis_tready) and double buffering. Sits between sensor RX and the video pipe.
// PARAMETERS
// - DATA_WIDTH  8   pixel bits
// - KERNEL      64  pixels per kernel; must be a multiple of TAPS
// - TAPS        4   interleaved taps per kernel; SEG = KERNEL/TAPS pixels per tap
// PORTS
// - i_clk          in   1           single clock, all logic on rising edge
// - i_reset        in   1           synchronous, active-high reset
// - i_width        in   13          active pixels per line; multiple of KERNEL, >= KERNEL
// - i_height       in   13          lines per frame, >= 1
// - i_odd_kernel   in   1           mirror mode, sampled at first beat of each kernel
// - s_axis_tdata   in   DATA_WIDTH  input pixel
// - s_axis_tvalid  in   1           input valid
// - s_axis_tuser   in   1           start of frame
// - s_axis_tready  out  1           input ready
// - m_axis_tdata   out  DATA_WIDTH  output pixel
// - m_axis_tvalid  out  1           output valid
// - m_axis_tuser   out  1           first pixel of frame
// - m_axis_tlast   out  1           last pixel of line
// - m_axis_tready  in   1           output ready
// - o_frame_err    out  1           sticky; tuser seen mid-kernel; cleared only by i_reset
// BEHAVIOUR
// - Reset values: s_axis_tready=0, m_axis_tvalid/tuser/tlast=0, m_axis_tdata=0, o_frame_err=0.
//   All counters = 0; both banks empty; write bank = 0, read bank = 0.
// - Mapping: input beat i (0..KERNEL-1) is split as t = i % TAPS, p = i / TAPS.
//   Output position = t*SEG + p. With latched odd=1, output position = t*SEG + (SEG-1-p).
// - Write side: s_axis_tready = ~full[wr_bank], registered; it is 1 the cycle after reset deasserts.
//   A transfer is tvalid&tready. Each transfer writes the bank at the remapped position and increments wr_idx.
//   At wr_idx==KERNEL-1 the bank is marked full, wr_bank toggles and wr_idx returns to 0.
// - Write-side tuser: on a transfer with tuser=1 and wr_idx!=0, the partial kernel is discarded.
//   That pixel is written as index 0 and o_frame_err is set.
//   The first kernel after any tuser is tagged sof; the tag is stored per bank.
// - Read side: when full[rd_bank], output is streamed in positions 0..KERNEL-1.
//   m_axis_tdata, tvalid, tuser and tlast are registered, using a skid-free output register.
//   The output register may advance only when ~m_axis_tvalid | m_axis_tready.
// - Read side holds data, tvalid, tuser and tlast stable while tvalid=1 and tready=0.
//   After the last position is consumed: full[rd_bank] clears and rd_bank toggles.
// - Latency: the first output pixel has tvalid=1 two cycles after the final input beat of a kernel is accepted.
//   Throughput is 1 pixel/clk sustained when tready stays high.
// - Bank release: a bank is released in the same cycle as its last pixel loads into the output register.
//   The write side may refill it from the next cycle.
// - Simultaneous events: full-set (write) and full-clear (read) on different banks in one cycle are both honoured.
// - Output counters: col 0..i_width-1, row 0..i_height-1.
//   tlast=1 when col==i_width-1. Row increments on tlast and wraps to 0 after i_height-1.
//   tuser=1 when col==0 && row==0.
//   A bank tagged sof forces col=row=0 before its first pixel; this resyncs a truncated frame.
// - i_width and i_height are quasi-static and may change only while both banks are empty.
// - Reset mid-operation: all buffered pixels are dropped, no partial output follows, and o_frame_err is cleared.
// STRUCTURE
// - Package sv_remapper_pkg holds:
//   - localparams SEG, IDX_W = $clog2(KERNEL);
//   - function remap_pos(idx, odd) returning the output position;
//   - typedef pixel_t of DATA_WIDTH bits.
// - Sub-module remap_kernel_bank holds one KERNEL x DATA_WIDTH register array with 1 write port and 1 read port
//   (wr_en, wr_addr, wr_data, rd_addr, rd_data). It is instantiated twice for ping-pong.
// - Top level contains the write FSM (IDLE/FILL), the read FSM (IDLE/STREAM) and the col/row counters.
// TESTING
// - KERNEL=8, TAPS=2, input 0..7, odd=0, tready=1 -> out 0,2,4,6,1,3,5,7; tvalid 2 clk after beat 7.
// - Same input with odd=1 -> out 6,4,2,0,7,5,3,1.
// - Default params, i_width=128, i_height=2, 4 kernels streamed:
//   -> tuser only on pixel 0; tlast on pixels 127 and 255; no gaps at tready=1.
// - tready toggled randomly at 50%: no pixel lost or duplicated; data held during stall.
//   s_axis_tready drops to 0 after 2 full kernels are buffered.
// - tuser injected at wr_idx=5: partial kernel dropped, o_frame_err=1.
//   Next output pixel carries tuser=1 with col=0, row=0.
// - i_reset asserted mid-stream for 1 clk -> all outputs 0 the next cycle.
//   Fresh frame afterwards remaps correctly; o_frame_err=0.

Source files
------------

// File: rtl/sv_remapper_pkg.sv
// sv_remapper_pkg
//   Shared types and helpers for the multitap remapper.
//   - DEF_*      : default geometry (8-bit pixels, 64-pixel kernel, 4 taps)
//   - SEG, IDX_W : pixels per tap and kernel index width for the defaults
//   - pixel_t    : one pixel at the default width
//   - remap_pos  : input beat index -> linear output position
package sv_remapper_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_KERNEL     = 64;
  localparam int DEF_TAPS       = 4;
  localparam int SEG            = DEF_KERNEL / DEF_TAPS;
  localparam int IDX_W          = $clog2(DEF_KERNEL);

  typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {W_IDLE, W_FILL}   wr_state_e;
  typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

  // Beat idx carries tap t = idx % taps, sample p = idx / taps. Tap t owns
  // output segment t; mirror mode walks each segment backwards.
  function automatic int remap_pos(input int idx, input logic odd,
                                   input int taps, input int kernel);
    int seg, t, p;
    seg = kernel / taps;
    t   = idx % taps;
    p   = idx / taps;
    return t * seg + (odd ? (seg - 1 - p) : p);
  endfunction

endpackage

// File: rtl/sv_remapper_multitap_bank.sv
// remap_kernel_bank
//   One kernel of pixel storage: a KERNEL x DATA_WIDTH register array with
//   one synchronous write port and one combinational read port.
//   Ports: i_clk; wr_en/wr_addr/wr_data (write); rd_addr -> rd_data (read).
module remap_kernel_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 64,
  parameter int AW         = $clog2(KERNEL)
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [KERNEL-1:0][DATA_WIDTH-1:0] mem;

  // Pixel storage needs no reset: bank full flags gate every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sv_remapper_multitap.sv
// sv_remapper_multitap
//   Reorders tap-interleaved sensor kernels into linear pixel order through a
//   ping-pong pair of kernel banks and regenerates tuser/tlast from the
//   programmed frame geometry. One pixel per beat in and out, full backpressure.
//   Ports:
//     i_clk, i_reset (sync, active high)
//     i_width, i_height : frame geometry (quasi-static)
//     i_odd_kernel      : mirror mode, taken at the first beat of each kernel
//     s_axis_*          : input stream (tdata/tvalid/tuser/tready)
//     m_axis_*          : output stream (tdata/tvalid/tuser/tlast/tready)
//     o_frame_err       : sticky, tuser arrived mid-kernel
module sv_remapper_multitap
  import sv_remapper_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KERNEL     = DEF_KERNEL,
  parameter int TAPS       = DEF_TAPS
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [12:0]           i_width,
  input  logic [12:0]           i_height,
  input  logic                  i_odd_kernel,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_frame_err
);

  localparam int AW = $clog2(KERNEL);
  localparam logic [AW-1:0] LAST_IDX = AW'(KERNEL - 1);

  wr_state_e wr_st;
  rd_state_e rd_st;

  logic [1:0]                 full, full_nxt, sof_tag;
  logic                       wr_bank, wr_bank_nxt, rd_bank;
  logic [AW-1:0]              wr_idx, eff_idx, wr_addr, rd_idx;
  logic                       odd_lat, kern_sof;
  logic                       xfer, restart, wr_done, adv, rd_load, rd_done;
  logic [1:0][DATA_WIDTH-1:0] bank_rd;
  logic [12:0]                col, row, col_use, row_use;
  logic                       eol;

  // ---------------- write side ----------------
  assign xfer    = s_axis_tvalid & s_axis_tready;
  // tuser in the middle of a kernel abandons it; this beat starts a new one.
  assign restart = s_axis_tuser && (wr_st == W_FILL);
  assign eff_idx = restart ? '0 : wr_idx;
  assign wr_addr = AW'(remap_pos(int'(eff_idx),
                                 (eff_idx == '0) ? i_odd_kernel : odd_lat,
                                 TAPS, KERNEL));
  assign wr_done = xfer && (eff_idx == LAST_IDX);

  // ---------------- read side ----------------
  assign adv     = ~m_axis_tvalid | m_axis_tready;
  assign rd_load = adv & full[rd_bank];
  assign rd_done = rd_load && (rd_idx == LAST_IDX);

  // Write only targets a non-full bank, read only a full one, so a set and a
  // clear in the same cycle always land on different banks.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end
  assign wr_bank_nxt = wr_bank ^ wr_done;

  // A sof-tagged bank restarts the raster at its first pixel.
  always_comb begin
    col_use = col;
    row_use = row;
    if (rd_st == R_IDLE && sof_tag[rd_bank]) begin
      col_use = '0;
      row_use = '0;
    end
  end
  assign eol = (col_use == i_width - 13'd1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    remap_kernel_bank #(.DATA_WIDTH(DATA_WIDTH), .KERNEL(KERNEL)) u_bank (
      .i_clk  (i_clk),
      .wr_en  (xfer && (wr_bank == 1'(b))),
      .wr_addr(wr_addr),
      .wr_data(s_axis_tdata),
      .rd_addr(rd_idx),
      .rd_data(bank_rd[b])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_st         <= W_IDLE;
      rd_st         <= R_IDLE;
      full          <= '0;
      sof_tag       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      odd_lat       <= 1'b0;
      kern_sof      <= 1'b0;
      col           <= '0;
      row           <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      full          <= full_nxt;
      wr_bank       <= wr_bank_nxt;
      s_axis_tready <= ~full_nxt[wr_bank_nxt];

      // write FSM
      if (xfer) begin
        if (eff_idx == '0) begin
          odd_lat  <= i_odd_kernel;
          kern_sof <= s_axis_tuser;
        end
        if (restart) o_frame_err <= 1'b1;
        if (wr_done) begin
          sof_tag[wr_bank] <= kern_sof;
          wr_idx           <= '0;
          wr_st            <= W_IDLE;
        end else begin
          wr_idx <= eff_idx + AW'(1);
          wr_st  <= W_FILL;
        end
      end

      // read FSM feeding the output register
      if (adv) begin
        if (full[rd_bank]) begin
          m_axis_tdata  <= bank_rd[rd_bank];
          m_axis_tvalid <= 1'b1;
          m_axis_tuser  <= (col_use == '0) && (row_use == '0);
          m_axis_tlast  <= eol;
          col           <= eol ? '0 : col_use + 13'd1;
          if (eol) row  <= (row_use == i_height - 13'd1) ? '0 : row_use + 13'd1;
          else     row  <= row_use;
          if (rd_done) begin
            rd_idx  <= '0;
            rd_bank <= ~rd_bank;
            rd_st   <= R_IDLE;
          end else begin
            rd_idx <= rd_idx + AW'(1);
            rd_st  <= R_STREAM;
          end
        end else begin
          m_axis_tvalid <= 1'b0;
          m_axis_tuser  <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      end
    end
  end

endmodule
